// File: rtl/mfe_led7seg_pkg.sv
// Shared types and helpers for the 74HC595 seven-segment scanner.
package mfe_led7seg_pkg;

  localparam int unsigned DEF_DIG_NUM = 8;
  localparam int unsigned DEF_SEG_NUM = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_DWELL
  } state_t;

  // Minimum bit width able to index v items (never less than 1).
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned w;
    w = 1;
    while (((32'd1 << w) < v) && (w < 32)) w++;
    return w;
  endfunction

  // Width of a counter that must reach the value n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return clogb2(n + 1);
  endfunction

endpackage

// File: rtl/mfe_hc595_serializer.sv
// Serialises one N-bit word MSB first onto a 74HC595 chain, then pulses the latch.
module mfe_hc595_serializer
  import mfe_led7seg_pkg::*;
#(
  parameter int unsigned N   = 16,
  parameter int unsigned DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] word,
  output logic         done_c,
  output logic         sclk,
  output logic         rclk,
  output logic         dio
);

  localparam int unsigned DW = clogb2(DIV);
  localparam int unsigned BW = cnt_width(N);

  state_t         state, state_nx;
  logic [DW-1:0]  div_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [N-1:0]   sr;
  logic           div_last;

  assign div_last = (div_cnt == DW'(DIV - 1));

  // Next-state and handshake decode.
  always_comb begin
    state_nx = state;
    done_c   = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_nx = ST_SHIFT_LO;
      ST_SHIFT_LO: if (div_last) state_nx = ST_SHIFT_HI;
      ST_SHIFT_HI: if (div_last) state_nx = (bit_cnt == BW'(N - 1)) ? ST_LATCH : ST_SHIFT_LO;
      ST_LATCH: begin
        if (div_last) begin
          state_nx = ST_IDLE;
          done_c   = 1'b1;
        end
      end
      default:     state_nx = ST_IDLE;
    endcase
  end

  // dio only moves at word load and on the falling sclk edge between bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      sclk    <= 1'b0;
      rclk    <= 1'b0;
      dio     <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= ((state_nx != state) || (state == ST_IDLE)) ? '0 : div_cnt + DW'(1);
      sclk    <= (state_nx == ST_SHIFT_HI);
      rclk    <= (state_nx == ST_LATCH);
      if ((state == ST_IDLE) && start) begin
        sr      <= word;
        dio     <= word[N-1];
        bit_cnt <= '0;
      end else if ((state == ST_SHIFT_HI) && div_last) begin
        sr      <= sr << 1;
        bit_cnt <= bit_cnt + BW'(1);
        if (state_nx == ST_SHIFT_LO) dio <= sr[N-2];
      end
    end
  end

endmodule

// File: rtl/mfe_led7seg_74hc595_scanner.sv
// Autonomous multiplexed 7-segment refresh: frame buffer, field assembly, dwell and digit sequencing.
module mfe_led7seg_74hc595_scanner
  import mfe_led7seg_pkg::*;
#(
  parameter int unsigned DIG_NUM   = DEF_DIG_NUM,
  parameter int unsigned SEG_NUM   = DEF_SEG_NUM,
  parameter int unsigned DIV       = 4,
  parameter int unsigned HOLD      = 100,
  parameter int unsigned SEG_INV   = 0,
  parameter int unsigned DIG_INV   = 0,
  parameter int unsigned SEG_FIRST = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        blank,
  input  logic                        wr_en,
  input  logic [clogb2(DIG_NUM)-1:0]  wr_addr,
  input  logic [SEG_NUM-1:0]          wr_data,
  output logic                        sclk,
  output logic                        rclk,
  output logic                        dio,
  output logic                        busy,
  output logic [clogb2(DIG_NUM)-1:0]  cur_dig,
  output logic                        frame_done
);

  localparam int unsigned AW        = clogb2(DIG_NUM);
  localparam int unsigned N         = DIG_NUM + SEG_NUM;
  localparam int unsigned HW        = cnt_width(HOLD);
  localparam int unsigned HOLD_LAST = (HOLD == 0) ? 0 : HOLD - 1;
  localparam logic [DIG_NUM-1:0] DIG_MASK = {DIG_NUM{DIG_INV != 0}};
  localparam logic [SEG_NUM-1:0] SEG_MASK = {SEG_NUM{SEG_INV != 0}};

  logic [SEG_NUM-1:0] fbuf [DIG_NUM];
  state_t             state, state_nx;
  logic [HW-1:0]      hold_cnt;
  logic [DIG_NUM-1:0] dig_field;
  logic [SEG_NUM-1:0] seg_field;
  logic [N-1:0]       word;
  logic               start_c, done_c, exit_c;

  assign dig_field = (DIG_NUM'(1) << cur_dig) ^ DIG_MASK;
  assign seg_field = (blank ? '0 : fbuf[cur_dig]) ^ SEG_MASK;
  assign word      = (SEG_FIRST != 0) ? {seg_field, dig_field} : {dig_field, seg_field};

  // Host writes land at the clock edge, so a LOAD in the same cycle still sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIG_NUM; i++) fbuf[i] <= '0;
    end else if (wr_en && (32'(wr_addr) < DIG_NUM)) begin
      fbuf[wr_addr] <= wr_data;
    end
  end

  // ST_SHIFT_LO here spans the whole serializer transaction, including its latch phase.
  always_comb begin
    state_nx = state;
    start_c  = 1'b0;
    exit_c   = 1'b0;
    case (state)
      ST_IDLE:     if (en) state_nx = ST_LOAD;
      ST_LOAD: begin
        start_c  = 1'b1;
        state_nx = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (done_c) begin
          if (HOLD == 0) exit_c = 1'b1;
          else           state_nx = ST_DWELL;
        end
      end
      ST_DWELL:    if (hold_cnt == HW'(HOLD_LAST)) exit_c = 1'b1;
      default:     state_nx = ST_IDLE;
    endcase
    if (exit_c) state_nx = en ? ST_LOAD : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      cur_dig    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_cnt   <= (state == ST_DWELL) ? hold_cnt + HW'(1) : '0;
      busy       <= (state_nx != ST_IDLE);
      frame_done <= exit_c && (cur_dig == AW'(DIG_NUM - 1));
      if (exit_c) cur_dig <= (cur_dig == AW'(DIG_NUM - 1)) ? '0 : cur_dig + AW'(1);
    end
  end

  mfe_hc595_serializer #(
    .N   (N),
    .DIV (DIV)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .start  (start_c),
    .word   (word),
    .done_c (done_c),
    .sclk   (sclk),
    .rclk   (rclk),
    .dio    (dio)
  );

endmodule

// File: tb/tb_mfe_led7seg_74hc595_scanner.sv
// Bench: captures the serial stream of two scanner configurations and checks it against a word/timing model.
module tb_mfe_led7seg_74hc595_scanner;

  localparam int unsigned DN = 8, SN = 8, DV = 4, HD = 100;
  localparam int unsigned N = DN + SN, T = 1 + 2 * DV * N + DV + HD, F = DN * T;
  localparam int unsigned A_DN = 4, A_SN = 7, A_DV = 1, A_HD = 0;
  localparam int unsigned A_N = A_DN + A_SN, A_T = 1 + 2 * A_DV * A_N + A_DV + A_HD, A_F = A_DN * A_T;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0, n_fail = 0;

  logic rst, en, blank, wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic sclk, rclk, dio, busy, frame_done;
  logic [2:0] cur_dig;

  logic a_rst, a_en, a_blank, a_wr_en;
  logic [1:0] a_wr_addr;
  logic [6:0] a_wr_data;
  logic a_sclk, a_rclk, a_dio, a_busy, a_frame_done;
  logic [1:0] a_cur_dig;

  mfe_led7seg_74hc595_scanner u_dut (
    .clk(clk), .rst(rst), .en(en), .blank(blank), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .sclk(sclk), .rclk(rclk), .dio(dio), .busy(busy),
    .cur_dig(cur_dig), .frame_done(frame_done)
  );

  mfe_led7seg_74hc595_scanner #(
    .DIG_NUM(A_DN), .SEG_NUM(A_SN), .DIV(A_DV), .HOLD(A_HD),
    .SEG_INV(1), .DIG_INV(1), .SEG_FIRST(1)
  ) u_alt (
    .clk(clk), .rst(a_rst), .en(a_en), .blank(a_blank), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .sclk(a_sclk), .rclk(a_rclk), .dio(a_dio), .busy(a_busy),
    .cur_dig(a_cur_dig), .frame_done(a_frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Passive capture of what a 74HC595 chain would see.
  int unsigned m_sh = 0, a_sh = 0;
  int m_bits = 0, a_bits = 0, m_fd_hi = 0, a_fd_hi = 0;
  longint m_rise = 0, a_rise = 0, m_sclk0 = -1;
  int unsigned m_words[$], a_words[$];
  int m_digs[$], a_digs[$], m_nb[$], a_nb[$];
  longint m_rt[$], a_rt[$], m_rw[$], a_rw[$], m_fd[$], a_fd[$];

  always @(posedge sclk) begin
    m_sh = (m_sh << 1) | 32'(dio);
    m_bits++;
    if (m_sclk0 < 0) m_sclk0 = longint'($time);
  end
  always @(posedge rclk) begin
    m_words.push_back(m_sh & ((32'd1 << N) - 1));
    m_digs.push_back(int'(cur_dig));
    m_nb.push_back(m_bits);
    m_rise = longint'($time);
    m_rt.push_back(m_rise);
    m_bits = 0;
  end
  always @(negedge rclk) m_rw.push_back(longint'($time) - m_rise);
  always @(posedge frame_done) m_fd.push_back(longint'($time));

  always @(posedge a_sclk) begin
    a_sh = (a_sh << 1) | 32'(a_dio);
    a_bits++;
  end
  always @(posedge a_rclk) begin
    a_words.push_back(a_sh & ((32'd1 << A_N) - 1));
    a_digs.push_back(int'(a_cur_dig));
    a_nb.push_back(a_bits);
    a_rise = longint'($time);
    a_rt.push_back(a_rise);
    a_bits = 0;
  end
  always @(negedge a_rclk) a_rw.push_back(longint'($time) - a_rise);
  always @(posedge a_frame_done) a_fd.push_back(longint'($time));

  always @(negedge clk) begin
    if (frame_done) m_fd_hi++;
    if (a_frame_done) a_fd_hi++;
  end

  // Expected serial word straight from the field rules.
  function automatic int unsigned exp_word(input int unsigned dn, input int unsigned sn,
      input int unsigned dinv, input int unsigned sinv, input int unsigned sf,
      input int unsigned dig, input int unsigned segs, input bit blk);
    int unsigned d, s;
    d = (32'd1 << dig) ^ ((dinv != 0) ? ((32'd1 << dn) - 1) : 32'd0);
    s = (blk ? 32'd0 : segs) ^ ((sinv != 0) ? ((32'd1 << sn) - 1) : 32'd0);
    return (sf != 0) ? ((s << dn) | d) : ((d << sn) | s);
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  int unsigned mdl[DN];
  int unsigned a_mdl[A_DN];
  int unsigned old3, new3, segs, val;
  int e0, e1, ae0, ae1, dig;
  longint t0, t1, ta0, ta1, texp;
  bit blk;

  initial begin
    rst = 1'b1; en = 1'b0; blank = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    a_rst = 1'b1; a_en = 1'b0; a_blank = 1'b0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sclk", longint'(sclk), 0);
    check("rst_rclk", longint'(rclk), 0);
    check("rst_dio", longint'(dio), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_cur_dig", longint'(cur_dig), 0);
    check("rst_frame_done", longint'(frame_done), 0);
    check("a_rst_busy", longint'(a_busy), 0);
    check("a_rst_sclk", longint'(a_sclk), 0);
    rst = 1'b0; a_rst = 1'b0;
    @(negedge clk);

    // Random frame buffer contents; digit 0 pinned to the "0" glyph.
    for (int d = 0; d < DN; d++) begin
      val = (d == 0) ? 32'h3F : $urandom_range(0, 255);
      mdl[d] = val;
      wr_en = 1'b1; wr_addr = 3'(d); wr_data = 8'(val);
      @(negedge clk);
    end
    wr_en = 1'b0;
    old3 = mdl[3];
    new3 = old3 ^ $urandom_range(1, 255);

    en = 1'b1; e0 = cyc + 1; t0 = longint'($time) + 5;
    @(negedge clk);
    check("load_busy", longint'(busy), 1);
    check("load_cur_dig", longint'(cur_dig), 0);
    wait_cyc(e0 + F - 1);
    check("wrap_before", longint'(cur_dig), 7);
    @(negedge clk);
    check("wrap_after", longint'(cur_dig), 0);

    wait_cyc(e0 + F + 3 * T);
    blank = 1'b1;
    @(negedge clk);
    blank = 1'b0;

    wait_cyc(e0 + 2 * F + 3 * T);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'(new3);
    @(negedge clk);
    wr_en = 1'b0;

    // Drop enable in the middle of digit 4's shift.
    wait_cyc(e0 + 4 * F + 4 * T + 60);
    en = 1'b0;
    wait_cyc(e0 + 4 * F + 5 * T - 1);
    check("drain_busy", longint'(busy), 1);
    check("drain_cur_dig", longint'(cur_dig), 4);
    @(negedge clk);
    check("idle_busy", longint'(busy), 0);
    check("idle_cur_dig", longint'(cur_dig), 5);
    repeat (20) @(negedge clk);
    check("idle_sclk", longint'(sclk), 0);
    check("idle_words", longint'(m_words.size()), 37);

    en = 1'b1; e1 = cyc + 1; t1 = longint'($time) + 5;
    wait_cyc(e1 + 3 * T - 10);
    en = 1'b0;
    wait_cyc(e1 + 3 * T + 5);
    check("end_busy", longint'(busy), 0);
    check("end_cur_dig", longint'(cur_dig), 0);

    check("first_sclk_t", m_sclk0, t0 + longint'(1 + DV) * 10);
    check("word_count", longint'(m_words.size()), 40);
    for (int j = 0; j < 40; j++) begin
      if (j < 37) begin
        dig = j % DN;
        texp = t0 + longint'(j * T + 1 + 2 * DV * N) * 10;
      end else begin
        dig = 5 + (j - 37);
        texp = t1 + longint'((j - 37) * T + 1 + 2 * DV * N) * 10;
      end
      blk = (j == DN + 3);
      segs = mdl[dig];
      if (dig == 3) segs = (j >= 3 * DN) ? new3 : old3;
      if (j < m_words.size()) begin
        check($sformatf("word[%0d]", j), longint'(m_words[j]),
              longint'(exp_word(DN, SN, 0, 0, 0, dig, segs, blk)));
        check($sformatf("dig[%0d]", j), longint'(m_digs[j]), longint'(dig));
        check($sformatf("bits[%0d]", j), longint'(m_nb[j]), longint'(N));
        check($sformatf("rclk_t[%0d]", j), m_rt[j], texp);
        check($sformatf("rclk_w[%0d]", j), m_rw[j], longint'(DV) * 10);
      end
    end
    check("fd_count", longint'(m_fd.size()), 5);
    check("fd_cycles", longint'(m_fd_hi), 5);
    for (int k = 0; k < 5; k++) begin
      texp = (k < 4) ? t0 + longint'((k + 1) * F) * 10 : t1 + longint'(3 * T) * 10;
      if (k < m_fd.size()) check($sformatf("fd_t[%0d]", k), m_fd[k], texp);
    end

    // Small inverted, segment-first configuration with no dwell.
    for (int d = 0; d < A_DN; d++) begin
      val = (d == 2) ? 32'h06 : $urandom_range(0, 127);
      a_mdl[d] = val;
      a_wr_en = 1'b1; a_wr_addr = 2'(d); a_wr_data = 7'(val);
      @(negedge clk);
    end
    a_wr_en = 1'b0;
    a_en = 1'b1; ae0 = cyc + 1; ta0 = longint'($time) + 5;

    // Reset lands in the high phase of bit 5 of digit 1, second frame.
    wait_cyc(ae0 + A_F + A_T + 2 + 2 * 5);
    check("a_pre_rst_sclk", longint'(a_sclk), 1);
    a_rst = 1'b1; a_en = 1'b0;
    @(negedge clk);
    check("a_rst_sclk2", longint'(a_sclk), 0);
    check("a_rst_rclk2", longint'(a_rclk), 0);
    check("a_rst_dio2", longint'(a_dio), 0);
    check("a_rst_busy2", longint'(a_busy), 0);
    check("a_rst_cur_dig2", longint'(a_cur_dig), 0);
    check("a_rst_words", longint'(a_words.size()), 5);
    a_rst = 1'b0; a_bits = 0;
    repeat (3) @(negedge clk);
    a_en = 1'b1; ae1 = cyc + 1; ta1 = longint'($time) + 5;
    wait_cyc(ae1 + 2);
    a_en = 1'b0;
    wait_cyc(ae1 + A_T + 3);
    check("a_end_busy", longint'(a_busy), 0);
    check("a_end_cur_dig", longint'(a_cur_dig), 1);

    check("a_word_count", longint'(a_words.size()), 6);
    for (int j = 0; j < 6; j++) begin
      dig = (j < 5) ? j % A_DN : 0;
      segs = (j < 5) ? a_mdl[dig] : 0;
      texp = (j < 5) ? ta0 + longint'(j * A_T + 1 + 2 * A_DV * A_N) * 10
                     : ta1 + longint'(1 + 2 * A_DV * A_N) * 10;
      if (j < a_words.size()) begin
        check($sformatf("a_word[%0d]", j), longint'(a_words[j]),
              longint'(exp_word(A_DN, A_SN, 1, 1, 1, dig, segs, 1'b0)));
        check($sformatf("a_dig[%0d]", j), longint'(a_digs[j]), longint'(dig));
        check($sformatf("a_bits[%0d]", j), longint'(a_nb[j]), longint'(A_N));
        check($sformatf("a_rclk_t[%0d]", j), a_rt[j], texp);
        check($sformatf("a_rclk_w[%0d]", j), a_rw[j], longint'(A_DV) * 10);
      end
    end
    check("a_fd_count", longint'(a_fd.size()), 1);
    check("a_fd_cycles", longint'(a_fd_hi), 1);
    if (a_fd.size() > 0) check("a_fd_t", a_fd[0], ta0 + longint'(A_F) * 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
